// File: rtl/eks_sched_if.sv
// Control/status bundle for the EksBlowfish key-schedule sequencer.
// The master drives the request side; the sequencer owns the status side.
interface eks_sched_if #(
    parameter int COST_MAX = 31
) ();
    logic                start;
    logic [5:0]          cost;
    logic                abort;
    logic                ready;
    logic                busy;
    logic [2:0]          phase;
    logic                phase_first;
    logic                phase_last;
    logic [COST_MAX:0]   loop_rem;
    logic                done;
    logic                cost_err;

    modport master (
        output start, cost, abort,
        input  ready, busy, phase, phase_first, phase_last, loop_rem, done, cost_err
    );

    modport slave (
        input  start, cost, abort,
        output ready, busy, phase, phase_first, phase_last, loop_rem, done, cost_err
    );
endinterface

// File: rtl/eks_sched.sv
// EksBlowfish phase sequencer: INIT, 2^cost KEY/SALT pairs, ENC_ITER encrypt passes, DONE.
// All status outputs are registered or decoded from registered state only.
module eks_sched #(
    parameter int COST_MAX = 31,
    parameter int EXP_CYC  = 521,
    parameter int ENC_CYC  = 192,
    parameter int ENC_ITER = 64
) (
    input  logic      clk,
    input  logic      rst_l,
    eks_sched_if.slave bus
);
    localparam int CYC_MAX = (EXP_CYC > ENC_CYC) ? EXP_CYC : ENC_CYC;
    localparam int CNT_W   = $clog2(CYC_MAX) + 1;
    localparam int PASS_W  = $clog2(ENC_ITER) + 1;
    localparam int LOOP_W  = COST_MAX + 1;

    localparam logic [CNT_W-1:0]  EXP_LAST  = CNT_W'(EXP_CYC - 1);
    localparam logic [CNT_W-1:0]  ENC_LAST  = CNT_W'(ENC_CYC - 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(ENC_ITER - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_KEY  = 3'd2,
        S_SALT = 3'd3,
        S_ENC  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PASS_W-1:0]   pass_q, pass_d;
    logic [LOOP_W-1:0]   loop_q, loop_d;
    logic                cost_err_q, cost_err_d;
    logic                busy_w;
    logic                phase_end;

    function automatic logic cost_ok(input logic [5:0] c);
        return (c >= 6'd4) && (c <= 6'(COST_MAX));
    endfunction

    assign busy_w    = (state_q == S_INIT) || (state_q == S_KEY) ||
                       (state_q == S_SALT) || (state_q == S_ENC);
    assign phase_end = (cnt_q == ((state_q == S_ENC) ? ENC_LAST : EXP_LAST));

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pass_q     <= '0;
            loop_q     <= '0;
            cost_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pass_q     <= pass_d;
            loop_q     <= loop_d;
            cost_err_q <= cost_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pass_d     = pass_q;
        loop_d     = loop_q;
        cost_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (cost_ok(bus.cost)) begin
                        loop_d  = LOOP_W'(1) << bus.cost;
                        cnt_d   = '0;
                        pass_d  = '0;
                        state_d = S_INIT;
                    end else begin
                        cost_err_d = 1'b1;
                    end
                end
            end
            S_INIT, S_KEY: begin
                if (phase_end) begin
                    cnt_d   = '0;
                    state_d = (state_q == S_INIT) ? S_KEY : S_SALT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SALT: begin
                if (phase_end) begin
                    cnt_d = '0;
                    if (loop_q > LOOP_W'(1)) begin
                        loop_d  = loop_q - LOOP_W'(1);
                        state_d = S_KEY;
                    end else begin
                        loop_d  = '0;
                        pass_d  = '0;
                        state_d = S_ENC;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ENC: begin
                if (phase_end) begin
                    cnt_d = '0;
                    if (pass_q == PASS_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        pass_d = pass_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides whatever transition the phase logic picked this edge.
        if (bus.abort && busy_w) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pass_d  = '0;
            loop_d  = '0;
        end
    end

    assign bus.ready       = (state_q == S_IDLE);
    assign bus.busy        = busy_w;
    assign bus.phase       = state_q;
    assign bus.phase_first = busy_w && (cnt_q == '0);
    assign bus.phase_last  = busy_w && phase_end;
    assign bus.loop_rem    = loop_q;
    assign bus.done        = (state_q == S_DONE);
    assign bus.cost_err    = cost_err_q;
endmodule

// File: doc/eks_sched.md
EKS_SCHED -- requirements
Module: eks_sched

Interface
REQ-001 Parameter COST_MAX, default 31: largest accepted cost exponent; range 4..31.
REQ-002 Parameter EXP_CYC, default 521: clock cycles per ExpandKey phase; must be >= 2.
REQ-003 Parameter ENC_CYC, default 192: clock cycles per ciphertext-encrypt pass; must be >= 2.
REQ-004 Parameter ENC_ITER, default 64: number of ciphertext-encrypt passes; must be >= 1.
REQ-005 Port clk, input, 1: the block's only clock; all state changes on its rising edge.
REQ-006 Port rst_l, input, 1: asynchronous active-low reset.
REQ-007 Port start, input, 1: request a new hash; sampled only in IDLE.
REQ-008 Port cost, input, 6: log2 of the loop count; sampled on the edge that accepts start.
REQ-009 Port abort, input, 1: synchronous cancel of a run in progress.
REQ-010 Port ready, output, 1: high in IDLE only.
REQ-011 Port busy, output, 1: high in INIT, KEY, SALT and ENC.
REQ-012 Port phase, output, 3: current state encoding: IDLE=0, INIT=1, KEY=2, SALT=3, ENC=4, DONE=5.
REQ-013 Port phase_first, output, 1: high in the first cycle of every phase instance.
REQ-014 Port phase_last, output, 1: high in the last cycle of every phase instance.
REQ-015 Port loop_rem, output, COST_MAX+1: remaining KEY/SALT loop iterations, including the current one.
REQ-016 Port done, output, 1: one-cycle pulse on successful completion.
REQ-017 Port cost_err, output, 1: one-cycle pulse when start is rejected for a bad cost.

Function
REQ-018 start with ready=1 and 4<=cost<=COST_MAX shall, on that edge, load loop_rem=2^cost, clear the cycle counter and enter INIT.
REQ-019 start with ready=1 and cost outside 4..COST_MAX shall pulse cost_err in the next cycle and leave the FSM in IDLE.
REQ-020 start shall be ignored whenever ready=0; no queuing.
REQ-021 INIT shall last exactly EXP_CYC cycles, then go to KEY.
REQ-022 KEY shall last exactly EXP_CYC cycles, then go to SALT.
REQ-023 SALT shall last EXP_CYC cycles.
REQ-024 SALT exit: loop_rem>1 -> decrement loop_rem and go to KEY; loop_rem=1 -> set loop_rem=0 and go to ENC.
REQ-025 ENC shall run ENC_ITER back-to-back passes of ENC_CYC cycles each.
REQ-026 phase_first and phase_last shall pulse per ENC pass, as for every other phase instance.
REQ-027 After the last ENC pass the FSM shall enter DONE for exactly one cycle, with done=1, then return to IDLE.
REQ-028 Cycle counter: width ceil(log2(max(EXP_CYC,ENC_CYC)))+1; wraps to 0 at every phase or pass boundary.
REQ-029 Pass counter: width ceil(log2(ENC_ITER))+1.
REQ-030 Neither counter shall overflow for any legal parameter set.
REQ-031 loop_rem shall be wide enough to hold 2^COST_MAX with no truncation.
REQ-032 abort in any busy state: the next state is IDLE, loop_rem is cleared and done does not pulse.
REQ-033 abort has priority over a phase transition occurring on the same edge.
REQ-034 abort in IDLE or DONE shall have no effect; a DONE cycle still completes with done=1.
REQ-035 start and abort high together in IDLE: start wins.
REQ-036 All outputs shall be registered, or decoded only from registered state; no combinational path from input to output.

Reset
REQ-037 When rst_l=0: state=IDLE, ready=1, busy=0, phase=0, phase_first=0, phase_last=0, loop_rem=0, done=0, cost_err=0, and all counters=0.
REQ-038 Reset asserted mid-run shall abandon the run immediately, without a done pulse.
REQ-039 After rst_l deasserts, the first start shall be accepted on the first rising edge.

Verification (EXP_CYC=4, ENC_CYC=3, ENC_ITER=2, COST_MAX=8)
REQ-040 Full run: start with cost=4 -> 16 KEY/SALT pairs; done pulses exactly 138 cycles after the accepting edge; 4+128+6 busy cycles; ready returns 1 the cycle after done.
REQ-041 Bad cost: start with cost=3, then cost=9 -> one cost_err pulse each; busy stays 0; phase stays 0.
REQ-042 Abort: abort in the 2nd cycle of the 5th SALT -> IDLE next cycle, loop_rem=0, no done; a following start with cost=5 completes after 4+256+6+1 cycles.
REQ-043 Ignored start: start pulsed during KEY and during DONE -> no restart; loop_rem sequence is unchanged.
REQ-044 Reset mid-ENC: rst_l pulsed low in the 2nd ENC pass -> all outputs at reset values asynchronously, with no clock edge needed.
REQ-045 Boundaries: cost=8 -> loop_rem loads 256 and counts down to 1 before ENC; phase_first and phase_last are never high together.
